// File: rtl/revaluate_pkg.sv
// ============================================================================
//  Module   : revaluate_pkg
//  Purpose  : Shared line geometry and loader state encodings for revaluate.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package revaluate_pkg;

  localparam int LINE_W    = 25;
  localparam int NUM_LINES = 64;
  localparam int IDX_W     = 6;

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  typedef enum logic [1:0] {
    FILL      = S_FILL,
    LAUNCH    = S_LAUNCH,
    WAIT_DONE = S_WAIT
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/revaluate_line_loader_if.sv
// ============================================================================
//  Module   : revaluate_line_loader_if
//  Purpose  : Line stream, launch handshake and read port of the line loader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface revaluate_line_loader_if #(
  parameter int DATA_W = revaluate_pkg::LINE_W,
  parameter int IDX_W  = revaluate_pkg::IDX_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              start;
  logic              finish;
  logic [IDX_W-1:0]  rd_index;
  logic [DATA_W-1:0] rd_data;
  logic [IDX_W:0]    wr_count;
  logic              busy;

  // Upstream source plus revaluate controller/datapath
  modport master (
    output in_valid, in_data, finish, rd_index,
    input  in_ready, start, rd_data, wr_count, busy
  );

  // The loader itself
  modport slave (
    input  in_valid, in_data, finish, rd_index,
    output in_ready, start, rd_data, wr_count, busy
  );

endinterface

`default_nettype wire

// File: rtl/revaluate_line_mem.sv
// ============================================================================
//  Module   : revaluate_line_mem
//  Purpose  : DEPTH x DATA_W line RAM, one write port, one registered read.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module revaluate_line_mem #(
  parameter int DATA_W = revaluate_pkg::LINE_W,
  parameter int DEPTH  = revaluate_pkg::NUM_LINES,
  parameter int IDX_W  = revaluate_pkg::IDX_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              we,
  input  wire logic [IDX_W-1:0]  waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [IDX_W-1:0]  raddr,
  output      logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Same-edge read of a location being written returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/revaluate_line_loader.sv
// ============================================================================
//  Module   : revaluate_line_loader
//  Purpose  : Collects one frame of lines, launches the controller, serves reads.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module revaluate_line_loader #(
  parameter int DATA_W = revaluate_pkg::LINE_W,
  parameter int DEPTH  = revaluate_pkg::NUM_LINES,
  parameter int IDX_W  = revaluate_pkg::IDX_W
) (
  input wire logic              clk,
  input wire logic              rst,
  revaluate_line_loader_if.slave lb
);

  import revaluate_pkg::*;

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DEPTH - 1);

  loader_state_t    r_state;
  logic [IDX_W-1:0] r_wr_ptr;
  logic [IDX_W:0]   r_wr_count;
  logic             r_start;
  logic             r_busy;
  logic             w_ready;
  logic             w_xfer;

  assign w_ready = (r_state == FILL);
  assign w_xfer  = lb.in_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FILL;
      r_wr_ptr   <= '0;
      r_wr_count <= '0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          r_start <= 1'b0;
          if (w_xfer) begin
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_wr_count <= r_wr_count + (IDX_W+1)'(1);
            // start is registered so it is high exactly during LAUNCH
            if (r_wr_ptr == C_LAST_IDX) begin
              r_state <= LAUNCH;
              r_start <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          r_start <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (lb.finish) begin
            r_state    <= FILL;
            r_wr_count <= '0;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state <= FILL;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  revaluate_line_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_line_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_xfer),
    .waddr (r_wr_ptr),
    .wdata (lb.in_data),
    .raddr (lb.rd_index),
    .rdata (lb.rd_data)
  );

  assign lb.in_ready = w_ready;
  assign lb.start    = r_start;
  assign lb.busy     = r_busy;
  assign lb.wr_count = r_wr_count;

endmodule

`default_nettype wire

// File: tb/tb_revaluate_line_loader.sv
// ============================================================================
//  Module   : tb_revaluate_line_loader
//  Purpose  : Directed/random checks of the line loader against a frame model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_revaluate_line_loader;

  localparam int DW = 25;
  localparam int IW = 6;
  localparam int NL = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  revaluate_line_loader_if #(.DATA_W(DW), .IDX_W(IW)) lb_if ();

  revaluate_line_loader #(.DATA_W(DW), .DEPTH(NL), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .lb  (lb_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Frame model: expected RAM image and number of lines in the current frame
  logic [DW-1:0] ref_mem [NL];
  int            cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input logic [DW-1:0] d);
    check("in_ready_fill", 32'(lb_if.in_ready), 32'd1);
    lb_if.in_valid = 1'b1;
    lb_if.in_data  = d;
    tick();
    lb_if.in_valid = 1'b0;
    ref_mem[cnt] = d;
    cnt++;
    check("wr_count", 32'(lb_if.wr_count), 32'(cnt));
    check("start", 32'(lb_if.start), 32'(cnt == NL));
    if (cnt == NL) begin
      check("in_ready_launch", 32'(lb_if.in_ready), 32'd0);
    end
  endtask

  task automatic idle();
    tick();
    check("start_idle", 32'(lb_if.start), 32'd0);
    check("wr_count_idle", 32'(lb_if.wr_count), 32'(cnt));
  endtask

  task automatic after_launch();
    tick();
    check("start_once", 32'(lb_if.start), 32'd0);
    check("busy_wait", 32'(lb_if.busy), 32'd1);
    check("in_ready_wait", 32'(lb_if.in_ready), 32'd0);
  endtask

  task automatic read_check(input int idx);
    lb_if.rd_index = IW'(idx);
    tick();
    check($sformatf("rd_data[%0d]", idx), 32'(lb_if.rd_data), 32'(ref_mem[idx]));
  endtask

  task automatic do_finish();
    lb_if.finish = 1'b1;
    tick();
    lb_if.finish = 1'b0;
    cnt = 0;
    check("busy_after_finish", 32'(lb_if.busy), 32'd0);
    check("in_ready_after_finish", 32'(lb_if.in_ready), 32'd1);
    check("wr_count_after_finish", 32'(lb_if.wr_count), 32'd0);
  endtask

  initial begin
    lb_if.in_valid = 1'b0;
    lb_if.in_data  = '0;
    lb_if.finish   = 1'b0;
    lb_if.rd_index = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(lb_if.in_ready), 32'd1);
    check("rst_start", 32'(lb_if.start), 32'd0);
    check("rst_busy", 32'(lb_if.busy), 32'd0);
    check("rst_wr_count", 32'(lb_if.wr_count), 32'd0);
    check("rst_rd_data", 32'(lb_if.rd_data), 32'd0);

    // Back-to-back frame, data = index*3
    for (int i = 0; i < NL; i++) send_line(DW'(i * 3));
    after_launch();
    read_check(0);
    read_check(17);
    read_check(63);

    // Input held during evaluation must be ignored
    lb_if.in_valid = 1'b1;
    lb_if.in_data  = 25'h1FFFFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("in_ready_blocked", 32'(lb_if.in_ready), 32'd0);
      check("wr_count_held", 32'(lb_if.wr_count), 32'd64);
    end
    for (int i = 0; i < NL; i++) read_check(i);
    do_finish();
    lb_if.in_valid = 1'b0;

    // Random gaps and random payloads; first line must land at index 0
    while (cnt < NL) begin
      if ($urandom_range(0, 1) == 0) idle();
      else send_line(DW'($urandom));
    end
    after_launch();
    for (int i = 0; i < NL; i++) read_check(i);
    do_finish();

    // Reset part-way through a frame discards progress
    for (int i = 0; i < 30; i++) send_line(DW'($urandom));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    check("midrst_wr_count", 32'(lb_if.wr_count), 32'd0);
    check("midrst_in_ready", 32'(lb_if.in_ready), 32'd1);
    check("midrst_start", 32'(lb_if.start), 32'd0);
    check("midrst_rd_data", 32'(lb_if.rd_data), 32'd0);
    for (int i = 0; i < NL; i++) send_line(DW'($urandom));
    after_launch();
    for (int i = 0; i < NL; i += 7) read_check(i);
    do_finish();

    // finish during FILL has no effect
    for (int i = 0; i < 10; i++) send_line(DW'($urandom));
    lb_if.finish = 1'b1;
    tick();
    lb_if.finish = 1'b0;
    check("fill_finish_wr_count", 32'(lb_if.wr_count), 32'd10);
    check("fill_finish_in_ready", 32'(lb_if.in_ready), 32'd1);
    check("fill_finish_busy", 32'(lb_if.busy), 32'd0);
    for (int i = 10; i < NL; i++) send_line(DW'($urandom));
    after_launch();
    read_check(0);
    read_check(9);
    read_check(10);
    read_check(63);
    do_finish();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
